// File: rtl/hwpe_ctrl_bist_pkg.sv
// Shared types and March C- element tables for the HWPE control regfile BIST.
// Table bit i describes element Ei.
package hwpe_ctrl_bist_pkg;

  localparam int unsigned MARCH_NUM_ELEM = 6;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } march_elem_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } bist_state_e;

  // 1 = ascending, 0 = descending address order
  localparam logic [MARCH_NUM_ELEM-1:0] MARCH_DIR_UP    = 6'b100111;
  localparam logic [MARCH_NUM_ELEM-1:0] MARCH_HAS_READ  = 6'b111110;
  localparam logic [MARCH_NUM_ELEM-1:0] MARCH_HAS_WRITE = 6'b011111;
  // 1 = inverted background
  localparam logic [MARCH_NUM_ELEM-1:0] MARCH_RD_POL    = 6'b010100;
  localparam logic [MARCH_NUM_ELEM-1:0] MARCH_WR_POL    = 6'b001010;

endpackage

// File: rtl/hwpe_ctrl_bist_addr_gen.sv
// Up/down address counter for the March sequencer with load to either end
// of the array and a terminal-count flag for the current direction.
module hwpe_ctrl_bist_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  load_top_i,
  input  logic                  en_i,
  input  logic                  up_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  tc_o
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_top_i ? ADDR_MAX : '0;
    end else if (en_i) begin
      addr_d = up_i ? (addr_q + ADDR_ONE) : (addr_q - ADDR_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign tc_o   = up_i ? (addr_q == ADDR_MAX) : (addr_q == '0);

endmodule

// File: rtl/hwpe_ctrl_regfile_bist.sv
// March C- BIST controller for the HWPE control register file: sequences the
// regfile test port, compares read data and records the first failure.
module hwpe_ctrl_regfile_bist
  import hwpe_ctrl_bist_pkg::*;
#(
  parameter int unsigned         ADDR_WIDTH = 5,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         NUM_BYTE   = DATA_WIDTH / 8,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [2:0]            fail_elem_o,
  output logic                  BIST_o,
  output logic                  CSN_T_o,
  output logic                  WEN_T_o,
  output logic [ADDR_WIDTH-1:0] A_T_o,
  output logic [DATA_WIDTH-1:0] D_T_o,
  output logic [NUM_BYTE-1:0]   BE_T_o,
  input  logic [DATA_WIDTH-1:0] Q_T_i
);

  localparam logic [DATA_WIDTH-1:0] BG_INV = ~BACKGROUND;

  bist_state_e           state_q, state_d;
  march_elem_e           elem_q, elem_d;
  logic                  phase_q, phase_d;
  logic                  csn_q, csn_d, wen_q, wen_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NUM_BYTE-1:0]   be_q, be_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0] rd_exp_q, rd_exp_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [2:0]            rd_elem_q, rd_elem_d;
  logic                  done_q, done_d, fail_q, fail_d;
  logic [ADDR_WIDTH-1:0] fail_addr_q, fail_addr_d;
  logic [2:0]            fail_elem_q, fail_elem_d;

  logic                  ag_load, ag_load_top, ag_en, ag_tc;
  logic [ADDR_WIDTH-1:0] ag_addr;
  logic                  cur_wr, pair_rd, nxt_wr, mismatch;

  hwpe_ctrl_bist_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) i_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (ag_load),
    .load_top_i (ag_load_top),
    .en_i       (ag_en),
    .up_i       (MARCH_DIR_UP[elem_q]),
    .addr_o     (ag_addr),
    .tc_o       (ag_tc)
  );

  // Counters always describe the operation currently on the test port.
  assign cur_wr  = MARCH_HAS_WRITE[elem_q] && (!MARCH_HAS_READ[elem_q] || phase_q);
  assign pair_rd = MARCH_HAS_READ[elem_q] && MARCH_HAS_WRITE[elem_q] && !phase_q;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    phase_d     = phase_q;
    ag_load     = 1'b0;
    ag_load_top = 1'b0;
    ag_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          elem_d  = E0;
          phase_d = 1'b0;
          ag_load = 1'b1;
        end
      end
      RUN: begin
        if (pair_rd) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          if (!ag_tc) begin
            ag_en = 1'b1;
          end else if (elem_q == E5) begin
            state_d = DRAIN;
            ag_load = 1'b1;
          end else begin
            elem_d      = march_elem_e'(elem_q + 3'd1);
            ag_load     = 1'b1;
            ag_load_top = ~MARCH_DIR_UP[elem_d];
          end
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clear_i) begin
      state_d     = IDLE;
      elem_d      = E0;
      phase_d     = 1'b0;
      ag_load     = 1'b1;
      ag_load_top = 1'b0;
      ag_en       = 1'b0;
    end
  end

  // Port outputs are registered from the decode of the next operation.
  always_comb begin
    nxt_wr  = MARCH_HAS_WRITE[elem_d] && (!MARCH_HAS_READ[elem_d] || phase_d);
    csn_d   = (state_d != RUN);
    wen_d   = !((state_d == RUN) && nxt_wr);
    wdata_d = '0;
    if ((state_d == RUN) && nxt_wr) begin
      wdata_d = MARCH_WR_POL[elem_d] ? BG_INV : BACKGROUND;
    end
    be_d = (state_d == RUN) ? '1 : '0;
  end

  assign mismatch = rd_pend_q && (Q_T_i != rd_exp_q);

  always_comb begin
    rd_pend_d   = (state_q == RUN) && !cur_wr && !clear_i;
    rd_exp_d    = MARCH_RD_POL[elem_q] ? BG_INV : BACKGROUND;
    rd_addr_d   = ag_addr;
    rd_elem_d   = elem_q;
    done_d      = done_q;
    fail_d      = fail_q;
    fail_addr_d = fail_addr_q;
    fail_elem_d = fail_elem_q;
    if ((state_q == IDLE) && start_i) begin
      done_d      = 1'b0;
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
    end else begin
      if (state_q == DRAIN) done_d = 1'b1;
      if (mismatch) begin
        fail_d = 1'b1;
        if (!fail_q) begin
          fail_addr_d = rd_addr_q;
          fail_elem_d = rd_elem_q;
        end
      end
    end
    if (clear_i) begin
      done_d      = 1'b0;
      fail_d      = 1'b0;
      fail_addr_d = '0;
      fail_elem_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      elem_q      <= E0;
      phase_q     <= 1'b0;
      csn_q       <= 1'b1;
      wen_q       <= 1'b1;
      wdata_q     <= '0;
      be_q        <= '0;
      rd_pend_q   <= 1'b0;
      rd_exp_q    <= '0;
      rd_addr_q   <= '0;
      rd_elem_q   <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      phase_q     <= phase_d;
      csn_q       <= csn_d;
      wen_q       <= wen_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      rd_pend_q   <= rd_pend_d;
      rd_exp_q    <= rd_exp_d;
      rd_addr_q   <= rd_addr_d;
      rd_elem_q   <= rd_elem_d;
      done_q      <= done_d;
      fail_q      <= fail_d;
      fail_addr_q <= fail_addr_d;
      fail_elem_q <= fail_elem_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign BIST_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;
  assign fail_elem_o = fail_elem_q;
  assign CSN_T_o     = csn_q;
  assign WEN_T_o     = wen_q;
  assign A_T_o       = ag_addr;
  assign D_T_o       = wdata_q;
  assign BE_T_o      = be_q;

endmodule

// File: tb/tb_hwpe_ctrl_regfile_bist.sv
// Directed bench for hwpe_ctrl_regfile_bist on a 4-word behavioural regfile
// with optional stuck-at and idempotent coupling faults.
module tb_hwpe_ctrl_regfile_bist;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned NB = 4;
  localparam logic [DW-1:0] BG     = 32'h5555_5555;
  localparam logic [DW-1:0] BG_INV = 32'hAAAA_AAAA;

  logic          clk = 1'b0;
  logic          rst_n, clear_i, start_i;
  logic          busy_o, done_o, fail_o, BIST_o, CSN_T_o, WEN_T_o;
  logic [AW-1:0] fail_addr_o, A_T_o;
  logic [2:0]    fail_elem_o;
  logic [DW-1:0] D_T_o, Q_T_i;
  logic [NB-1:0] BE_T_o;

  int n_tests = 0;
  int n_fail  = 0;
  int fault_mode = 0;  // 0 none, 1 addr2 bit3 stuck-at-1, 2 coupling 3->1

  int busy_cnt, op_cnt, wr_cnt, seq_err, done_cyc;
  logic done_c1, fail_c1;

  logic [DW-1:0] mem [4];

  always #5 clk = ~clk;

  hwpe_ctrl_regfile_bist #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_BYTE   (NB),
    .BACKGROUND (BG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .fail_o      (fail_o),
    .fail_addr_o (fail_addr_o),
    .fail_elem_o (fail_elem_o),
    .BIST_o      (BIST_o),
    .CSN_T_o     (CSN_T_o),
    .WEN_T_o     (WEN_T_o),
    .A_T_o       (A_T_o),
    .D_T_o       (D_T_o),
    .BE_T_o      (BE_T_o),
    .Q_T_i       (Q_T_i)
  );

  // Behavioural regfile, read data valid the cycle after the request.
  always @(posedge clk) begin
    if (BIST_o && !CSN_T_o) begin
      if (!WEN_T_o) begin
        mem[A_T_o] <= D_T_o;
        if (fault_mode == 2 && A_T_o == 2'd3 && D_T_o == BG_INV) mem[1][0] <= BG_INV[0];
      end else begin
        Q_T_i <= (fault_mode == 1 && A_T_o == 2'd2) ? (mem[A_T_o] | 32'h8) : mem[A_T_o];
      end
    end
  end

  // Starts a run in the current cycle and follows it until done_o or a cycle bound.
  task automatic do_run(input int pulse_at, input int clear_at);
    int cyc, oi, e, k, ea;
    logic ew;
    logic [DW-1:0] exp_d;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    cyc = 1; busy_cnt = 0; op_cnt = 0; wr_cnt = 0; seq_err = 0; done_cyc = -1;
    done_c1 = done_o; fail_c1 = fail_o;
    while (cyc < 100 && done_cyc < 0) begin
      if (busy_o) busy_cnt++;
      if (!CSN_T_o) begin
        oi = op_cnt;
        if (oi < 4) begin
          ea = oi; ew = 1'b1;
        end else if (oi < 36) begin
          e  = (oi - 4) / 8 + 1;
          k  = (oi - 4) % 8;
          ea = (e <= 2) ? k / 2 : 3 - k / 2;
          ew = (k % 2) == 1;
        end else begin
          ea = oi - 36; ew = 1'b0;
        end
        if (A_T_o !== ea[1:0] || WEN_T_o !== !ew) seq_err++;
        if (BE_T_o !== 4'hF) seq_err++;
        if (!WEN_T_o) begin
          exp_d = ((wr_cnt / 4) % 2 == 1) ? BG_INV : BG;
          if (D_T_o !== exp_d) seq_err++;
          wr_cnt++;
        end
        op_cnt++;
      end
      if (done_o) done_cyc = cyc;
      if (cyc == pulse_at) start_i = 1'b1;
      if (cyc == clear_at) clear_i = 1'b1;
      if (done_cyc < 0) begin
        @(posedge clk); #1;
        start_i = 1'b0;
        clear_i = 1'b0;
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({busy_o, done_o, fail_o, BIST_o, CSN_T_o, WEN_T_o} !== 6'b000011) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 000011", {busy_o, done_o, fail_o, BIST_o, CSN_T_o, WEN_T_o});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({fail_addr_o, fail_elem_o, A_T_o, D_T_o, BE_T_o, busy_o, CSN_T_o} !== {2'd0, 3'd0, 2'd0, 32'd0, 4'd0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL idle_values got fa=%0d fe=%0d A=%0d D=%h BE=%h busy=%b csn=%b want zeros csn=1",
               fail_addr_o, fail_elem_o, A_T_o, D_T_o, BE_T_o, busy_o, CSN_T_o);
    end
  endtask

  task automatic check_clean_run(input string tag);
    n_tests++;
    if (busy_cnt != 41 || done_cyc != 42) begin
      n_fail++;
      $display("FAIL %s_timing got busy=%0d done_cyc=%0d want 41/42", tag, busy_cnt, done_cyc);
    end
    n_tests++;
    if (fail_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_fail got %b want 0", tag, fail_o);
    end
  endtask

  task automatic test_fault_free();
    fault_mode = 0;
    do_run(0, 0);
    check_clean_run("fault_free");
    n_tests++;
    if (op_cnt != 40 || wr_cnt != 20) begin
      n_fail++;
      $display("FAIL op_counts got ops=%0d writes=%0d want 40/20", op_cnt, wr_cnt);
    end
    n_tests++;
    if (seq_err != 0) begin
      n_fail++;
      $display("FAIL op_sequence got %0d bad ops want 0", seq_err);
    end
  endtask

  task automatic test_stuck_at();
    fault_mode = 1;
    do_run(0, 0);
    n_tests++;
    if ({fail_o, fail_addr_o, fail_elem_o} !== {1'b1, 2'd2, 3'd1}) begin
      n_fail++;
      $display("FAIL stuck_at got fail=%b addr=%0d elem=%0d want 1/2/1", fail_o, fail_addr_o, fail_elem_o);
    end
    n_tests++;
    if (busy_cnt != 41 || done_cyc != 42) begin
      n_fail++;
      $display("FAIL stuck_timing got busy=%0d done_cyc=%0d want 41/42", busy_cnt, done_cyc);
    end
  endtask

  task automatic test_coupling();
    fault_mode = 2;
    do_run(0, 0);
    n_tests++;
    if ({fail_o, fail_addr_o, fail_elem_o} !== {1'b1, 2'd1, 3'd3}) begin
      n_fail++;
      $display("FAIL coupling got fail=%b addr=%0d elem=%0d want 1/1/3", fail_o, fail_addr_o, fail_elem_o);
    end
  endtask

  task automatic test_async_reset();
    fault_mode = 0;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    n_tests++;
    if (busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_busy got %b want 1", busy_o);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy_o, done_o, fail_o, BIST_o, CSN_T_o, WEN_T_o, A_T_o, D_T_o, BE_T_o} !==
        {6'b000011, 2'd0, 32'd0, 4'd0}) begin
      n_fail++;
      $display("FAIL async_reset got busy=%b bist=%b csn=%b wen=%b A=%0d D=%h BE=%h want idle values",
               busy_o, BIST_o, CSN_T_o, WEN_T_o, A_T_o, D_T_o, BE_T_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_run(0, 0);
    check_clean_run("post_reset");
  endtask

  task automatic test_restart_ignored();
    fault_mode = 0;
    do_run(10, 0);
    check_clean_run("restart");
  endtask

  task automatic test_clear();
    fault_mode = 1;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    n_tests++;
    if (fail_o !== 1'b1 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_clear got fail=%b busy=%b want 1/1", fail_o, busy_o);
    end
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    n_tests++;
    if ({busy_o, done_o, fail_o, CSN_T_o, fail_elem_o} !== {4'b0001, 3'd0}) begin
      n_fail++;
      $display("FAIL clear got busy=%b done=%b fail=%b csn=%b elem=%0d want 0/0/0/1/0",
               busy_o, done_o, fail_o, CSN_T_o, fail_elem_o);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_stays_idle got busy=%b done=%b want 0/0", busy_o, done_o);
    end
  endtask

  task automatic test_back_to_back();
    fault_mode = 1;
    do_run(0, 0);
    n_tests++;
    if (done_o !== 1'b1 || fail_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first got done=%b fail=%b want 1/1", done_o, fail_o);
    end
    fault_mode = 0;
    do_run(0, 0);
    n_tests++;
    if (done_c1 !== 1'b0 || fail_c1 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_start_clears got done=%b fail=%b want 0/0", done_c1, fail_c1);
    end
    check_clean_run("b2b_second");
    n_tests++;
    if (seq_err != 0 || wr_cnt != 20) begin
      n_fail++;
      $display("FAIL b2b_data got bad=%0d writes=%0d want 0/20", seq_err, wr_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; clear_i = 1'b0; Q_T_i = '0;
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_coupling();
    test_async_reset();
    test_restart_ignored();
    test_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
